// File: rtl/mc_control_fsm.sv
// Multicycle CPU control unit: decodes the IR and sequences fetch/decode/execute/
// memory/write-back, with memory wait handshake, idle/halt, sticky trap and retire count.
module mc_control_fsm #(
  parameter int unsigned IW       = 32,
  parameter int unsigned ALUOP_W  = 4,
  parameter logic [3:0]  ADD_OP   = 4'b0010,
  parameter bit          MEM_WAIT = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IW-1:0]      instr_in,
  input  logic               mem_ready,
  input  logic               halt,
  output logic [3:0]         state,
  output logic               PCWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               BranchType,
  output logic               LUI,
  output logic               SW,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               trap,
  output logic               busy,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_EXEC_I = 4'd4,
    S_EXEC_R = 4'd5,
    S_BRANCH = 4'd6,
    S_JUMP   = 4'd7,
    S_MEM_RD = 4'd8,
    S_MEM_WR = 4'd9,
    S_ALU_WB = 4'd10,
    S_LD_WB  = 4'd11,
    S_LI_EX  = 4'd12,
    S_LUI_EX = 4'd13,
    S_IMM_WB = 4'd14,
    S_TRAP   = 4'd15
  } state_e;

  localparam logic [ALUOP_W-1:0] ADD_EXT = ALUOP_W'(ADD_OP);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;
  logic               ready;
  logic [1:0]         cls;
  logic [3:0]         op;
  logic [ALUOP_W-1:0] op_ext;
  logic               is_noop, is_load, is_store;
  logic               unused_instr;

  assign cls      = instr_in[IW-1:IW-2];
  assign op       = instr_in[IW-3:IW-6];
  assign op_ext   = ALUOP_W'(op);
  assign ready    = MEM_WAIT ? mem_ready : 1'b1;
  assign is_noop  = (instr_in[IW-1:IW-6] == 6'd0);
  assign is_load  = (cls == 2'b11) && ((op == 4'b1011) || (op == 4'b1101));
  assign is_store = (cls == 2'b11) && ((op == 4'b1100) || (op == 4'b1110));
  assign unused_instr = ^instr_in[IW-7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    PCWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    RegWrite   = 1'b0;
    BranchType = 1'b0;
    LUI        = 1'b0;
    SW         = 1'b0;
    PCSource   = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = '0;
    trap       = 1'b0;
    busy       = (state_q != S_IDLE) && (state_q != S_TRAP);

    case (state_q)
      S_IDLE: if (!halt) state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ADD_EXT;
        PCWrite = ready;
        IRWrite = ready;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (is_noop) begin
          retire  = 1'b1;
          state_d = halt ? S_IDLE : S_FETCH;
        end else begin
          case (cls)
            2'b00:   state_d = S_JUMP;
            2'b01:   state_d = S_EXEC_R;
            2'b10:   state_d = S_BRANCH;
            default: begin
              case (op)
                4'b1001:                            state_d = S_LI_EX;
                4'b1010:                            state_d = S_LUI_EX;
                4'b1011, 4'b1101, 4'b1100, 4'b1110: state_d = S_MEMADR;
                4'b1111:                            state_d = S_TRAP;
                default:                            state_d = S_EXEC_I;
              endcase
            end
          endcase
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = ADD_EXT;
        SW      = is_store;
        state_d = is_store ? S_MEM_WR : S_MEM_RD;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = op_ext;
        state_d = S_ALU_WB;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = op_ext;
        state_d = S_ALU_WB;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        if (ready) state_d = S_LD_WB;
      end
      // Store retires on the handshake cycle itself; MemWrite/SW held through wait.
      S_MEM_WR: begin
        MemWrite = 1'b1;
        SW       = 1'b1;
        if (ready) begin
          retire  = 1'b1;
          state_d = halt ? S_IDLE : S_FETCH;
        end
      end
      S_LI_EX, S_LUI_EX: begin
        ALUSrcB = 2'b11;
        ALUOp   = op_ext;
        LUI     = (state_q == S_LUI_EX);
        state_d = S_IMM_WB;
      end
      S_BRANCH, S_JUMP, S_ALU_WB, S_LD_WB, S_IMM_WB: begin
        PCWrite    = (state_q == S_BRANCH) || (state_q == S_JUMP);
        BranchType = (state_q == S_BRANCH);
        PCSource   = (state_q == S_JUMP) ? 2'b10 : 2'b00;
        RegWrite   = (state_q == S_ALU_WB) || (state_q == S_LD_WB) || (state_q == S_IMM_WB);
        MemtoReg   = (state_q == S_LD_WB);
        LUI        = (state_q == S_IMM_WB) && (op == 4'b1010);
        retire     = 1'b1;
        state_d    = halt ? S_IDLE : S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_IDLE;
    endcase

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-cycle expected state/controls/retired queued with stimulus.
module tb_mc_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_ready, halt;
  logic [31:0] instr_in;
  logic [3:0]  state;
  logic        PCWrite, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, BranchType, LUI, SW;
  logic [1:0]  PCSource, ALUSrcB;
  logic [3:0]  ALUOp;
  logic        trap, busy;
  logic [15:0] retired;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .mem_ready(mem_ready), .halt(halt),
    .state(state), .PCWrite(PCWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .BranchType(BranchType),
    .LUI(LUI), .SW(SW), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .trap(trap), .busy(busy), .retired(retired)
  );

  // Second instance: narrow counter for wrap, no memory wait handshake.
  logic        rst2;
  logic        halt2 = 1'b0, mr2 = 1'b0;
  logic [31:0] instr2 = 32'h0;
  logic [3:0]  st2, ret2, aop2;
  logic        pcw2, mrd2, mwr2, irw2, m2r2, asa2, rgw2, brt2, lui2, sw2, trp2, bsy2;
  logic [1:0]  pcs2, asb2;

  mc_control_fsm #(.CNT_W(4), .MEM_WAIT(1'b0)) dut_w (
    .clk(clk), .reset(rst2), .instr_in(instr2), .mem_ready(mr2), .halt(halt2),
    .state(st2), .PCWrite(pcw2), .MemRead(mrd2), .MemWrite(mwr2), .IRWrite(irw2),
    .MemtoReg(m2r2), .ALUSrcA(asa2), .RegWrite(rgw2), .BranchType(brt2),
    .LUI(lui2), .SW(sw2), .PCSource(pcs2), .ALUSrcB(asb2), .ALUOp(aop2),
    .trap(trp2), .busy(bsy2), .retired(ret2)
  );

  int total = 0;
  int bad   = 0;
  logic [15:0] ret_exp = '0;

  localparam logic [19:0] PCW = 20'h80000, MRD = 20'h40000, MWR = 20'h20000, IRW = 20'h10000;
  localparam logic [19:0] M2R = 20'h08000, ASA = 20'h04000, RGW = 20'h02000, BRT = 20'h01000;
  localparam logic [19:0] LUB = 20'h00800, SWB = 20'h00400, TRP = 20'h00002, BSY = 20'h00001;

  function automatic logic [19:0] pcs(input logic [1:0] v); return {10'b0, v, 8'b0}; endfunction
  function automatic logic [19:0] asb(input logic [1:0] v); return {12'b0, v, 6'b0}; endfunction
  function automatic logic [19:0] aop(input logic [3:0] v); return {14'b0, v, 2'b0}; endfunction

  typedef struct {
    string       tag;
    logic        rst, mr, hl;
    logic [31:0] ins;
    logic [3:0]  st;
    logic [19:0] cv;
    logic [15:0] ret;
  } ent_t;
  ent_t sbq[$];

  task automatic push(input string tag, input logic rst_v, input logic mr_v, input logic hl_v,
                      input logic [31:0] ins, input logic [3:0] st, input logic [19:0] cv);
    ent_t e;
    e.tag = tag; e.rst = rst_v; e.mr = mr_v; e.hl = hl_v; e.ins = ins;
    e.st = st; e.cv = cv; e.ret = ret_exp;
    sbq.push_back(e);
  endtask

  task automatic push_fetch(input logic [31:0] ins);
    push("fetch", 1'b0, 1'b1, 1'b0, ins, 4'd1, PCW | MRD | IRW | asb(2'b01) | aop(4'b0010) | BSY);
  endtask

  task automatic push_decode(input logic [31:0] ins, input logic hl_v);
    push("decode", 1'b0, 1'b1, hl_v, ins, 4'd2, asb(2'b11) | BSY);
  endtask

  // Drives one cycle of stimulus at the falling edge and returns what the DUT shows.
  task automatic step(input ent_t e, output logic [3:0] ost, output logic [19:0] ocv,
                      output logic [15:0] oret);
    @(negedge clk);
    reset = e.rst; mem_ready = e.mr; halt = e.hl; instr_in = e.ins;
    #1;
    ost  = state;
    ocv  = {PCWrite, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, BranchType,
            LUI, SW, PCSource, ALUSrcB, ALUOp, trap, busy};
    oret = retired;
  endtask

  task automatic test_reset();
    ent_t e; logic [3:0] ost; logic [19:0] ocv; logic [15:0] oret;
    push("reset_hold", 1'b1, 1'b1, 1'b0, 32'h0, 4'd0, 20'h0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); step(e, ost, ocv, oret); total++;
      if ({ost, ocv, oret} !== {e.st, e.cv, e.ret}) begin
        bad++;
        $display("FAIL %s: state=%0d ctl=%h retired=%h, want state=%0d ctl=%h retired=%h",
                 e.tag, ost, ocv, oret, e.st, e.cv, e.ret);
      end
    end
  endtask

  task automatic test_rtype();
    ent_t e; logic [3:0] ost; logic [19:0] ocv; logic [15:0] oret;
    push("idle_after_reset", 1'b0, 1'b1, 1'b0, 32'h4400_0000, 4'd0, 20'h0);
    push_fetch(32'h4400_0000);
    push_decode(32'h4400_0000, 1'b0);
    push("exec_r", 1'b0, 1'b1, 1'b0, 32'h4400_0000, 4'd5, ASA | asb(2'b00) | aop(4'b0001) | BSY);
    push("alu_wb", 1'b0, 1'b1, 1'b0, 32'h4400_0000, 4'd10, RGW | BSY);
    ret_exp++;
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); step(e, ost, ocv, oret); total++;
      if ({ost, ocv, oret} !== {e.st, e.cv, e.ret}) begin
        bad++;
        $display("FAIL %s: state=%0d ctl=%h retired=%h, want state=%0d ctl=%h retired=%h",
                 e.tag, ost, ocv, oret, e.st, e.cv, e.ret);
      end
    end
  endtask

  task automatic test_load();
    ent_t e; logic [3:0] ost; logic [19:0] ocv; logic [15:0] oret;
    push_fetch(32'hEC00_0000);
    push_decode(32'hEC00_0000, 1'b0);
    push("memadr_ld", 1'b0, 1'b1, 1'b0, 32'hEC00_0000, 4'd3, ASA | asb(2'b10) | aop(4'b0010) | BSY);
    for (int i = 0; i < 3; i++)
      push("mem_rd_wait", 1'b0, 1'b0, 1'b0, 32'hEC00_0000, 4'd8, MRD | BSY);
    push("mem_rd", 1'b0, 1'b1, 1'b0, 32'hEC00_0000, 4'd8, MRD | BSY);
    push("ld_wb", 1'b0, 1'b1, 1'b0, 32'hEC00_0000, 4'd11, RGW | M2R | BSY);
    ret_exp++;
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); step(e, ost, ocv, oret); total++;
      if ({ost, ocv, oret} !== {e.st, e.cv, e.ret}) begin
        bad++;
        $display("FAIL %s: state=%0d ctl=%h retired=%h, want state=%0d ctl=%h retired=%h",
                 e.tag, ost, ocv, oret, e.st, e.cv, e.ret);
      end
    end
  endtask

  task automatic test_store();
    ent_t e; logic [3:0] ost; logic [19:0] ocv; logic [15:0] oret;
    push("fetch_wait", 1'b0, 1'b0, 1'b0, 32'hF000_0000, 4'd1, MRD | asb(2'b01) | aop(4'b0010) | BSY);
    push_fetch(32'hF000_0000);
    push_decode(32'hF000_0000, 1'b0);
    push("memadr_st", 1'b0, 1'b1, 1'b0, 32'hF000_0000, 4'd3,
         ASA | asb(2'b10) | aop(4'b0010) | SWB | BSY);
    push("mem_wr", 1'b0, 1'b1, 1'b0, 32'hF000_0000, 4'd9, MWR | SWB | BSY);
    ret_exp++;
    push_fetch(32'hF800_0000);
    push_decode(32'hF800_0000, 1'b0);
    push("memadr_st2", 1'b0, 1'b1, 1'b0, 32'hF800_0000, 4'd3,
         ASA | asb(2'b10) | aop(4'b0010) | SWB | BSY);
    push("mem_wr_wait", 1'b0, 1'b0, 1'b0, 32'hF800_0000, 4'd9, MWR | SWB | BSY);
    push("mem_wr2", 1'b0, 1'b1, 1'b0, 32'hF800_0000, 4'd9, MWR | SWB | BSY);
    ret_exp++;
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); step(e, ost, ocv, oret); total++;
      if ({ost, ocv, oret} !== {e.st, e.cv, e.ret}) begin
        bad++;
        $display("FAIL %s: state=%0d ctl=%h retired=%h, want state=%0d ctl=%h retired=%h",
                 e.tag, ost, ocv, oret, e.st, e.cv, e.ret);
      end
    end
  endtask

  task automatic test_back_to_back();
    ent_t e; logic [3:0] ost; logic [19:0] ocv; logic [15:0] oret;
    push_fetch(32'h0000_0000);
    push_decode(32'h0000_0000, 1'b0);
    ret_exp++;
    push_fetch(32'h0400_0000);
    push_decode(32'h0400_0000, 1'b0);
    push("jump", 1'b0, 1'b1, 1'b0, 32'h0400_0000, 4'd7, PCW | pcs(2'b10) | BSY);
    ret_exp++;
    push_fetch(32'h8000_0000);
    push_decode(32'h8000_0000, 1'b0);
    push("branch", 1'b0, 1'b1, 1'b0, 32'h8000_0000, 4'd6, PCW | BRT | BSY);
    ret_exp++;
    push_fetch(32'hCC00_0000);
    push_decode(32'hCC00_0000, 1'b0);
    push("exec_i", 1'b0, 1'b1, 1'b0, 32'hCC00_0000, 4'd4, ASA | asb(2'b10) | aop(4'b0011) | BSY);
    push("alu_wb_i", 1'b0, 1'b1, 1'b0, 32'hCC00_0000, 4'd10, RGW | BSY);
    ret_exp++;
    push_fetch(32'hE400_0000);
    push_decode(32'hE400_0000, 1'b0);
    push("li_ex", 1'b0, 1'b1, 1'b0, 32'hE400_0000, 4'd12, asb(2'b11) | aop(4'b1001) | BSY);
    push("imm_wb_li", 1'b0, 1'b1, 1'b0, 32'hE400_0000, 4'd14, RGW | BSY);
    ret_exp++;
    push_fetch(32'hE800_0000);
    push_decode(32'hE800_0000, 1'b0);
    push("lui_ex", 1'b0, 1'b1, 1'b0, 32'hE800_0000, 4'd13, asb(2'b11) | aop(4'b1010) | LUB | BSY);
    push("imm_wb_lui", 1'b0, 1'b1, 1'b0, 32'hE800_0000, 4'd14, RGW | LUB | BSY);
    ret_exp++;
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); step(e, ost, ocv, oret); total++;
      if ({ost, ocv, oret} !== {e.st, e.cv, e.ret}) begin
        bad++;
        $display("FAIL %s: state=%0d ctl=%h retired=%h, want state=%0d ctl=%h retired=%h",
                 e.tag, ost, ocv, oret, e.st, e.cv, e.ret);
      end
    end
  endtask

  task automatic test_halt();
    ent_t e; logic [3:0] ost; logic [19:0] ocv; logic [15:0] oret;
    push_fetch(32'h0400_0000);
    push_decode(32'h0400_0000, 1'b1);
    push("jump_halt", 1'b0, 1'b1, 1'b1, 32'h0400_0000, 4'd7, PCW | pcs(2'b10) | BSY);
    ret_exp++;
    push("idle_halt", 1'b0, 1'b1, 1'b1, 32'h0400_0000, 4'd0, 20'h0);
    push("idle_halt2", 1'b0, 1'b1, 1'b1, 32'h0400_0000, 4'd0, 20'h0);
    push("idle_release", 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'd0, 20'h0);
    push_fetch(32'h0000_0000);
    push_decode(32'h0000_0000, 1'b1);
    ret_exp++;
    push("idle_after_noop", 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'd0, 20'h0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); step(e, ost, ocv, oret); total++;
      if ({ost, ocv, oret} !== {e.st, e.cv, e.ret}) begin
        bad++;
        $display("FAIL %s: state=%0d ctl=%h retired=%h, want state=%0d ctl=%h retired=%h",
                 e.tag, ost, ocv, oret, e.st, e.cv, e.ret);
      end
    end
  endtask

  task automatic test_reset_midwrite();
    ent_t e; logic [3:0] ost; logic [19:0] ocv; logic [15:0] oret;
    push_fetch(32'hF000_0000);
    push_decode(32'hF000_0000, 1'b0);
    push("memadr_st", 1'b0, 1'b1, 1'b0, 32'hF000_0000, 4'd3,
         ASA | asb(2'b10) | aop(4'b0010) | SWB | BSY);
    push("mem_wr_wait", 1'b0, 1'b0, 1'b0, 32'hF000_0000, 4'd9, MWR | SWB | BSY);
    push("mem_wr_wait2", 1'b0, 1'b0, 1'b0, 32'hF000_0000, 4'd9, MWR | SWB | BSY);
    ret_exp = '0;
    push("reset_in_mem_wr", 1'b1, 1'b0, 1'b0, 32'hF000_0000, 4'd0, 20'h0);
    push("idle_post_reset", 1'b0, 1'b1, 1'b0, 32'hF000_0000, 4'd0, 20'h0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); step(e, ost, ocv, oret); total++;
      if ({ost, ocv, oret} !== {e.st, e.cv, e.ret}) begin
        bad++;
        $display("FAIL %s: state=%0d ctl=%h retired=%h, want state=%0d ctl=%h retired=%h",
                 e.tag, ost, ocv, oret, e.st, e.cv, e.ret);
      end
    end
  endtask

  task automatic test_trap();
    ent_t e; logic [3:0] ost; logic [19:0] ocv; logic [15:0] oret;
    push_fetch(32'hFC00_0000);
    push_decode(32'hFC00_0000, 1'b0);
    push("trap_enter", 1'b0, 1'b1, 1'b0, 32'hFC00_0000, 4'd15, TRP);
    for (int i = 0; i < 20; i++)
      push("trap_hold", 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, 4'd15, TRP);
    push("reset_trap", 1'b1, 1'b1, 1'b0, 32'h0, 4'd0, 20'h0);
    push("idle_post_trap", 1'b0, 1'b1, 1'b1, 32'h0, 4'd0, 20'h0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); step(e, ost, ocv, oret); total++;
      if ({ost, ocv, oret} !== {e.st, e.cv, e.ret}) begin
        bad++;
        $display("FAIL %s: state=%0d ctl=%h retired=%h, want state=%0d ctl=%h retired=%h",
                 e.tag, ost, ocv, oret, e.st, e.cv, e.ret);
      end
    end
  endtask

  // NOOP stream on the 4-bit, no-wait instance with mem_ready held low.
  task automatic test_wrap();
    logic [3:0] q_st[$];
    logic [3:0] q_ret[$];
    logic       q_pcw[$];
    logic [3:0] es, er;
    logic       ep;
    q_st.push_back(4'd0); q_ret.push_back(4'd0); q_pcw.push_back(1'b0);
    for (int unsigned k = 0; k < 18; k++) begin
      q_st.push_back(4'd1); q_ret.push_back(4'(k)); q_pcw.push_back(1'b1);
      q_st.push_back(4'd2); q_ret.push_back(4'(k)); q_pcw.push_back(1'b0);
    end
    while (q_st.size() > 0) begin
      @(negedge clk);
      rst2 = 1'b0;
      #1;
      es = q_st.pop_front(); er = q_ret.pop_front(); ep = q_pcw.pop_front();
      total++;
      if ({st2, pcw2, ret2} !== {es, ep, er}) begin
        bad++;
        $display("FAIL wrap: state=%0d pcwrite=%b retired=%h, want state=%0d pcwrite=%b retired=%h",
                 st2, pcw2, ret2, es, ep, er);
      end
    end
  endtask

  initial begin
    reset = 1'b1; rst2 = 1'b1;
    mem_ready = 1'b1; halt = 1'b0; instr_in = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_rtype();
    test_load();
    test_store();
    test_back_to_back();
    test_halt();
    test_reset_midwrite();
    test_trap();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
